nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder.sv | 99 +++++++++
 tb/tb_nibble_serial_adder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - nibble-serial wide adder built on a 4-bit lookahead slice
// One nibble per clock, LSB first; start/busy/done handshake, one add in flight.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   opa, opb;
  logic           carry;
  logic [IW-1:0]  index;
  logic [IW+1:0]  base;
  logic [3:0]     na, nb, g, p, c, nsum;
  logic           c4;
  logic           last;

  // Lookahead slice on the nibble selected by index; carry chain is flat, not rippled.
  always_comb begin
    base = {index, 2'b00};
    na   = opa[base +: 4];
    nb   = opb[base +: 4];
    g    = na & nb;
    p    = na ^ nb;
    c[0] = carry;
    c[1] = g[0] | (p[0] & carry);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
    c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & carry);
    nsum = p ^ c;
    last = (index == IW'(NIBBLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      index <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          opa   <= a;
          opb   <= b;
          carry <= cin;
          index <= '0;
          sum   <= '0;
          cout  <= 1'b0;
        end
      end else begin
        sum[base +: 4] <= nsum;
        carry          <= c4;
        index          <= index + 1'b1;
        if (last) begin
          cout <= c4;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed vectors for nibble_serial_adder (NIBBLES=4 and 1)
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0;
  logic        busy, done, cout;
  logic [15:0] sum;

  logic        start1 = 1'b0;
  logic [3:0]  a1 = '0, b1 = '0;
  logic        cin1 = 1'b0;
  logic        busy1, done1, cout1;
  logic [3:0]  sum1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one add on the 4-nibble instance and check it; returns in the done cycle.
  task automatic add4(input string tag, input logic [15:0] av, input logic [15:0] bv,
                      input logic ci, input logic [15:0] es, input logic ec);
    a = av; b = bv; cin = ci; start = 1'b1;
    tick;
    start = 1'b0;
    chk({tag, ".busy_e0"}, busy, 1);
    for (int k = 1; k <= 4; k++) begin
      tick;
      if (k < 4) chk($sformatf("%s.done_e%0d", tag, k), done, 0);
    end
    chk({tag, ".done"}, done, 1);
    chk({tag, ".busy_end"}, busy, 0);
    chk({tag, ".sum"}, sum, es);
    chk({tag, ".cout"}, cout, ec);
  endtask

  task automatic add1(input string tag, input logic [3:0] av, input logic [3:0] bv,
                      input logic ci, input logic [3:0] es, input logic ec);
    a1 = av; b1 = bv; cin1 = ci; start1 = 1'b1;
    tick;
    start1 = 1'b0;
    chk({tag, ".busy_e0"}, busy1, 1);
    chk({tag, ".done_e0"}, done1, 0);
    tick;
    chk({tag, ".done"}, done1, 1);
    chk({tag, ".busy_end"}, busy1, 0);
    chk({tag, ".sum"}, sum1, es);
    chk({tag, ".cout"}, cout1, ec);
    tick;
    chk({tag, ".done_clr"}, done1, 0);
  endtask

  initial begin
    // Reset held with random inputs and start asserted
    start = 1'b1; start1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      a1 = 4'($urandom); b1 = 4'($urandom);
      tick;
    end
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.sum", sum, 0);
    chk("rst.cout", cout, 0);
    chk("rst.busy1", busy1, 0);
    start = 1'b0; start1 = 1'b0;
    rst_n = 1'b1;
    tick;

    add4("first", 16'h0005, 16'h0006, 1'b1, 16'h000C, 1'b0);
    tick;
    chk("first.done_clr", done, 0);
    chk("first.sum_hold", sum, 16'h000C);

    add4("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    tick;
    add4("max", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    tick;
    add4("mix", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    tick;

    // Start raised again before E2 must be ignored
    a = 16'h00F0; b = 16'h0010; cin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    tick;
    start = 1'b0;
    chk("ign.done_e2", done, 0);
    tick;
    chk("ign.done_e3", done, 0);
    tick;
    chk("ign.done_e4", done, 1);
    chk("ign.sum", sum, 16'h0100);
    chk("ign.cout", cout, 0);
    for (int i = 0; i < 6; i++) begin
      tick;
      chk($sformatf("ign.no_second_%0d", i), done, 0);
    end

    // Reset between E2 and E3 aborts the add
    a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    chk("abort.busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.sum", sum, 0);
    chk("abort.cout", cout, 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("abort.no_done_%0d", i), done, 0);
    end
    rst_n = 1'b1;
    tick;
    add4("post", 16'h0008, 16'h0008, 1'b0, 16'h0010, 1'b0);

    // Start in the done cycle is accepted straight away
    add4("b2b", 16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0);
    tick;
    chk("b2b.done_clr", done, 0);

    add1("n1a", 4'h5, 4'h6, 1'b1, 4'hC, 1'b0);
    add1("n1b", 4'hF, 4'h1, 1'b0, 4'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
